// File: rtl/frame_pkg.sv
// Shared types and constants for the framed serial transmit path (scheduler, receiver, encoder).
package frame_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} tx_state_t;

    localparam logic [1:0] PREAMBLE   = 2'b11;
    localparam int         PRE_LEN    = 2;
    localparam int         CW_DEFAULT = 14;
endpackage

// File: rtl/frame_tx_sched_if.sv
// Requester/serial-side bundle of frame_tx_sched; master = codeword sources, slave = scheduler.
interface frame_tx_sched_if
    import frame_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CW   = CW_DEFAULT
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*CW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               dout;
    logic               busy;
    logic [IW-1:0]      grant_id;
    logic               frame_done;

    modport master (output req_valid, req_data,
                    input  req_ready, dout, busy, grant_id, frame_done);
    modport slave  (input  req_valid, req_data,
                    output req_ready, dout, busy, grant_id, frame_done);
endinterface

// File: rtl/frame_tx_sched_rr_arbiter.sv
// One-hot arbiter, combinational grant; FRAME_TX_RR_EN selects round-robin, else fixed lowest-index priority.
// Pointer moves to winner+1 only on advance, so an unaccepted request keeps its turn.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);
    logic w_found;

`ifdef FRAME_TX_RR_EN
    logic [IW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                w_found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[k]) begin
                grant[k] = 1'b1;
                idx      = IW'(k);
                w_found  = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/frame_tx_sched.sv
// Arbitrates NREQ codeword sources onto one serial line: 11 preamble, CW bits MSB first, GAP idle zeros.
// Accept to first preamble bit is 1 cycle; sources wait on req_ready, only offered in IDLE (FRAME_TX_RR_EN: round-robin).
module frame_tx_sched
    import frame_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CW   = CW_DEFAULT,
    parameter int GAP  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    frame_tx_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(CW);
    localparam int GW = $clog2(GAP + 1);
    localparam int PW = $clog2(PRE_LEN);

    localparam logic [BW-1:0] BIT_LAST = BW'(CW - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);

    // The GAP parameter hides the enum literal, so the gap state is always package-qualified.
    tx_state_t       r_state, w_state_nxt;
    logic [CW-1:0]   r_shreg;
    logic [BW-1:0]   r_bit_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [PW-1:0]   r_pre_cnt;
    logic            r_dout, r_busy;
    logic [IW-1:0]   r_grant_id;
    logic            w_dout_nxt, w_shift, w_accept;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (w_accept),
        .grant   (w_grant),
        .idx     (w_idx)
    );

    assign w_accept       = (r_state == IDLE) && (|bus.req_valid);
    assign bus.req_ready  = (w_accept && rst_n) ? w_grant : '0;
    assign bus.frame_done = (r_state == frame_pkg::GAP) && (r_gap_cnt == GAP_LAST);
    assign bus.dout       = r_dout;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // dout is registered, so each state computes the bit for the cycle after it.
    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PRE;
                    w_dout_nxt  = PREAMBLE[1];
                end
            end
            PRE: begin
                if (r_pre_cnt == PRE_LAST) begin
                    w_state_nxt = DATA;
                    w_dout_nxt  = r_shreg[CW-1];
                    w_shift     = 1'b1;
                end else begin
                    w_dout_nxt  = PREAMBLE[0];
                end
            end
            DATA: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_state_nxt = frame_pkg::GAP;
                end else begin
                    w_dout_nxt  = r_shreg[CW-1];
                    w_shift     = 1'b1;
                end
            end
            frame_pkg::GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_dout     <= 1'b0;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
        end else begin
            if (w_accept) begin
                r_shreg    <= bus.req_data[int'(w_idx)*CW +: CW];
                r_grant_id <= w_idx;
            end else if (w_shift) begin
                r_shreg    <= {r_shreg[CW-2:0], 1'b0};
            end
            r_pre_cnt <= (r_state == PRE && w_state_nxt == PRE) ? r_pre_cnt + 1'b1 : '0;
            r_bit_cnt <= (r_state == DATA && w_state_nxt == DATA) ? r_bit_cnt + 1'b1 : '0;
            r_gap_cnt <= (r_state == frame_pkg::GAP && w_state_nxt == frame_pkg::GAP)
                         ? r_gap_cnt + 1'b1 : '0;
            r_dout    <= w_dout_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_frame_tx_sched.sv
// Directed bench for frame_tx_sched with NREQ=2, CW=14, GAP=2 (frame period 19).
module tb_frame_tx_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    frame_tx_sched_if #(.NREQ(2), .CW(14)) bus ();

    frame_tx_sched #(.NREQ(2), .CW(14), .GAP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  vld;
        logic [13:0] d0;
        logic [13:0] d1;
        int          g;
        logic [13:0] word;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output logic ok);
        int n;
        n = 0;
        while (!(|bus.req_ready) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = |bus.req_ready;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_frame(input vec_t v);
        logic        ok;
        logic [17:0] bits;
        logic        fd_early;
        bits     = '0;
        fd_early = 1'b0;
        @(negedge clk);
        bus.req_valid = v.vld;
        bus.req_data  = {v.d1, v.d0};
        #1;
        wait_ready(ok);
        if (ok) begin
            chk("ready_onehot", {30'd0, bus.req_ready}, 32'd1 << v.g);
            @(posedge clk);
            #1;
            bus.req_valid = 2'b00;
            for (int i = 1; i <= 18; i++) begin
                @(negedge clk);
                bits = {bits[16:0], bus.dout};
                if (i == 1) begin
                    chk("grant_id", {31'd0, bus.grant_id}, v.g);
                    chk("busy_first", {31'd0, bus.busy}, 32'd1);
                end
                if (i < 18 && bus.frame_done) fd_early = 1'b1;
                if (i == 18) begin
                    chk("frame_done_last", {31'd0, bus.frame_done}, 32'd1);
                    chk("busy_last", {31'd0, bus.busy}, 32'd1);
                end
            end
            chk("dout_seq", {14'd0, bits}, {14'd0, 2'b11, v.word, 2'b00});
            chk("frame_done_early", {31'd0, fd_early}, 32'd0);
            @(negedge clk);
            chk("busy_after", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        logic ok;
        int   acc_cyc[4];
        int   acc_g[4];
        int   t0;
        logic seen;

        tbl[0] = '{2'b01, 14'b10110011100101, 14'h0000, 0, 14'b10110011100101};
        tbl[1] = '{2'b10, 14'h0000, 14'h3FFF, 1, 14'h3FFF};
        tbl[2] = '{2'b01, 14'h0001, 14'h1234, 0, 14'h0001};
        tbl[3] = '{2'b10, 14'h3FFF, 14'h2AAA, 1, 14'h2AAA};

        // Reset held with both requesters asserting.
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data  = {14'h2AAA, 14'h1555};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_dout", {31'd0, bus.dout}, 32'd0);
            chk("rst_ready", {30'd0, bus.req_ready}, 32'd0);
            chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        end
        chk("rst_grant_id", {31'd0, bus.grant_id}, 32'd0);
        chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_accept", {30'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_idle();

        for (int i = 0; i < 4; i++) run_frame(tbl[i]);

        // Contention: both held valid for four frames.
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_data  = {14'h2AAA, 14'h1555};
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(ok);
            acc_cyc[i] = cyc;
            acc_g[i]   = (bus.req_ready == 2'b10) ? 1 : 0;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
`ifdef FRAME_TX_RR_EN
            chk("contention_grant", acc_g[i], i % 2);
`else
            chk("contention_grant", acc_g[i], 32'd0);
`endif
            if (i > 0) chk("contention_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd19);
        end
        wait_idle();

        // Late request: requester 1 rises during DATA of requester 0's frame.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_data  = {14'h0F0F, 14'h1111};
        #1;
        wait_ready(ok);
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 5) begin
                bus.req_valid = 2'b10;
                #1;
            end
            if (i >= 5 && (|bus.req_ready)) seen = 1'b1;
        end
        chk("late_no_ready", {31'd0, seen}, 32'd0);
        @(negedge clk);
        #1;
        chk("late_ready", {30'd0, bus.req_ready}, 32'd2);
        chk("late_spacing", cyc - t0, 32'd19);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_idle();

        // Reset during data bit 5 of an all-ones word.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_data  = {14'h0000, 14'h3FFF};
        #1;
        wait_ready(ok);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        for (int i = 1; i <= 8; i++) @(negedge clk);
        chk("mid_dout_before", {31'd0, bus.dout}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_dout_async", {31'd0, bus.dout}, 32'd0);
        chk("mid_busy_async", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.frame_done || bus.busy || bus.dout) seen = 1'b1;
        end
        chk("mid_no_resend", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_tx_sched.md
# frame_tx_sched

Transmit-side scheduler that shares one serial link between `NREQ` requesters of 14-bit Hamming codewords. It arbitrates, latches the granted codeword, and shifts it out one bit per clock behind a `11` preamble, so the serial-to-parallel receiver at the far end can frame it. After each frame it inserts a run of idle zeros, so the receiver is back in IDLE before the next preamble. It sits between the Hamming encoders and the serial channel model.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `CW`, default 14: codeword width in bits.
- `GAP`, default 2: idle zero bits after each frame, minimum 2.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock, also the bit clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input NREQ: requester i has a codeword pending.
- `req_data` input NREQ*CW: codeword i in bits [i*CW +: CW]; bit CW-1 is sent first.
- `req_ready` output NREQ: one-cycle accept pulse, at most one bit set.
- `dout` output 1: serial line, registered.
- `busy` output 1: high from PRE through GAP.
- `grant_id` output $clog2(NREQ): index of the requester being served; holds its last value when idle.
- `frame_done` output 1: one-cycle pulse on the last GAP cycle.

## Operation
States: IDLE, PRE, DATA, GAP.
- **IDLE**
  - `dout`=0.
  - If any `req_valid` is set, the arbiter picks a winner w.
  - `req_ready[w]`=1 this cycle, and `req_data[w]` is latched into the shift register.
  - `grant_id`<=w, and the next state is PRE.
  - Otherwise stay in IDLE.
- **PRE**: 2 cycles, `dout`=1 both cycles, then DATA.
- **DATA**
  - CW cycles, MSB first: `dout`=shreg[CW-1], then shreg shifts left by 1 with zero fill.
  - A bit counter counts 0..CW-1; at CW-1 go to GAP.
- **GAP**: GAP cycles with `dout`=0. `frame_done`=1 on the last of them, then IDLE.

Arbitration and handshake rules:
- Requests are sampled only in IDLE; `req_valid` seen in other states is ignored.
- A requester holds `req_valid` and stable data until it sees `req_ready`.
- A requester may deassert `req_valid` in the accept cycle or re-assert it for the next word.
- Round-robin pointer p:
  - The search starts at (last winner + 1) mod NREQ.
  - After reset p=0, so requester 0 has priority first.
- Counters:
  - Bit counter width is $clog2(CW).
  - Gap counter width is $clog2(GAP+1).
  - Both clear on entry to their state; no wrap beyond the terminal count.

Reset values (async on `rst_n`=0):
- State IDLE; `dout`=0, `busy`=0, `req_ready`=0, `grant_id`=0, `frame_done`=0.
- shreg=0, counters=0, p=0.
- Reset mid-frame aborts the frame immediately. `dout` goes to 0 asynchronously, and the aborted word is not re-sent.

## Timing
- `dout`, `busy` and `grant_id` are registered and change on the `clk` edge after the state transition. `req_ready` and `frame_done` are decoded from the current state.
- Accept cycle is T. The preamble drives `dout` in T+1 and T+2. Data bit CW-1 is on `dout` in T+3, and bit 0 in T+2+CW.
- Gap occupies T+3+CW through T+2+CW+GAP. The earliest next accept is T+3+CW+GAP.
- Back-to-back frame period is 3+CW+GAP cycles, 19 with the defaults.
- `busy` is high from T+1 through T+2+CW+GAP.
- Simultaneous requests resolve in the same IDLE cycle, with exactly one winner.

## Configuration
- `FRAME_TX_RR_EN` defined: round-robin arbitration as described above.
- Undefined: fixed priority, where the lowest index wins and the pointer logic is removed. A requester can then be starved; this is acceptable for single-source links.

## Structure
- Shared package `frame_pkg`:
  - State enum `tx_state_t` {IDLE, PRE, DATA, GAP}.
  - `PREAMBLE` = 2'b11 and `PRE_LEN` = 2.
  - `CW_DEFAULT` = 14, reused by the receiver and the encoder.
- Sub-module `rr_arbiter`:
  - Parameter NREQ; inputs `req` and `advance`; outputs a one-hot `grant` and an index.
  - The pointer lives inside it; under `FRAME_TX_RR_EN` undefined it degrades to a priority encoder.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with `req_valid`=2'b11 → `dout`=0, `req_ready`=0, `busy`=0 throughout. The first accept is on requester 0 in the first cycle after release.
- **Single frame**: `req_valid[0]`=1, `req_data[0]`=14'b10110011100101 → `dout` sequence 1,1,1,0,1,1,0,0,1,1,1,0,0,1,0,1,0,0, then `frame_done` on the 18th cycle after accept. Looping `dout` into the receiver yields `hammingcode`=14'b10110011100101.
- **Contention, round-robin**: both requesters valid continuously → grants 0,1,0,1, accepts spaced exactly 19 cycles apart. With the macro undefined, grants are 0,0,0,0.
- **Late request**: `req_valid[1]` rises during DATA → no `req_ready` until the next IDLE, with `req_ready[1]`=1 exactly 19 cycles after the previous accept.
- **All-ones data**: `req_data`=14'h3FFF → 16 consecutive ones, then 2 zeros. The receiver recovers 14'h3FFF and resynchronises on the next preamble.
- **Reset mid-DATA**: assert `rst_n`=0 at bit 5 → `dout`=0 immediately, state IDLE after release, and no `frame_done` for the aborted frame.
